usb_data_buffer_wide: RTL and testbench

Parametrised, width-converting data buffer between the USB packet engines and the AHB-lite slave. It is a single circular byte store shared by both transfer directions. The USB side moves one byte per strobe; the host side moves 1, 2 or 4 bytes per strobe. Unlike the fixed 64-byte, byte-wide buffer, it adds atomic multi-byte host accesses, sticky overflow/underflow flags, and an optional watermark feature.

---
 rtl/usb_data_buffer_wide.sv | 216 +++++++++++++++++++++
 tb/tb_usb_data_buffer_wide.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_data_buffer_wide.sv
// usb_data_buffer_wide
// Circular byte store shared by the USB packet engines (one byte per strobe)
// and the AHB-lite host side (1, 2 or 4 bytes per strobe, atomic).
// Sticky overflow/underflow flags record rejected pushes/pops.
// Optional watermark outputs room_avail/word_avail: define USB_BUF_WATERMARK_EN.
module usb_data_buffer_wide #(
  parameter int DEPTH      = 64,
  parameter int HOST_BYTES = 4,
  parameter int OCC_W      = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    clear,
  input  logic                    store_rx_packet_data,
  input  logic [7:0]              rx_packet_data,
  input  logic                    get_tx_packet_data,
  output logic [7:0]              tx_packet_data,
  input  logic                    store_tx_data,
  input  logic [1:0]              tx_size,
  input  logic [8*HOST_BYTES-1:0] tx_data,
  input  logic                    get_rx_data,
  input  logic [1:0]              rx_size,
  output logic [8*HOST_BYTES-1:0] rx_data,
  output logic [OCC_W-1:0]        buffer_occupancy,
  output logic                    overflow,
  output logic                    underflow
`ifdef USB_BUF_WATERMARK_EN
  ,
  output logic                    room_avail,
  output logic                    word_avail
`endif
);

  localparam int               AW       = $clog2(DEPTH);
  localparam int               MAX_CODE = $clog2(HOST_BYTES);
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] ONE_C    = OCC_W'(1);

  // Size code 3 is never legal; codes above log2(HOST_BYTES) exceed the bus.
  function automatic logic code_legal(input logic [1:0] code);
    return (code != 2'd3) && (int'(code) <= MAX_CODE);
  endfunction

  function automatic logic [OCC_W-1:0] code_bytes(input logic [1:0] code);
    logic [OCC_W-1:0] n;
    case (code)
      2'd0:    n = OCC_W'(1);
      2'd1:    n = OCC_W'(2);
      default: n = OCC_W'(4);
    endcase
    return n;
  endfunction

  logic [7:0]              mem_q [DEPTH];
  logic [OCC_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic [7:0]              tx_byte_q, tx_byte_d;
  logic [8*HOST_BYTES-1:0] rx_word_q, rx_word_d;
  logic                    ovf_q, ovf_d;
  logic                    udf_q, udf_d;

  logic                    kill;
  logic [OCC_W-1:0]        free_bytes;
  logic [OCC_W-1:0]        host_push_n, host_pop_m;
  logic [OCC_W-1:0]        push_n, pop_m;
  logic                    usb_push_ok, host_push_ok, push_rej;
  logic                    usb_pop_ok, host_pop_ok, pop_rej;

  logic [AW-1:0]           waddr   [HOST_BYTES];
  logic [AW-1:0]           raddr   [HOST_BYTES];
  logic [7:0]              wbyte   [HOST_BYTES];
  logic [7:0]              rbyte   [HOST_BYTES];
  logic [HOST_BYTES-1:0]   lane_we;

  // Arbitrate strobes and decide acceptance against the pre-edge occupancy.
  always_comb begin
    kill        = rst | flush | clear;
    free_bytes  = DEPTH_C - occ_q;
    host_push_n = code_bytes(tx_size);
    host_pop_m  = code_bytes(rx_size);

    usb_push_ok  = ~kill & store_rx_packet_data & (free_bytes != '0);
    host_push_ok = ~kill & store_tx_data & ~store_rx_packet_data
                   & code_legal(tx_size) & (free_bytes >= host_push_n);
    push_rej     = ~kill & ((store_rx_packet_data & ~usb_push_ok)
                          | (store_tx_data & ~host_push_ok));

    usb_pop_ok   = ~kill & get_tx_packet_data & (occ_q != '0);
    host_pop_ok  = ~kill & get_rx_data & ~get_tx_packet_data
                   & code_legal(rx_size) & (occ_q >= host_pop_m);
    pop_rej      = ~kill & ((get_tx_packet_data & ~usb_pop_ok)
                          | (get_rx_data & ~host_pop_ok));

    push_n = '0;
    if (usb_push_ok) begin
      push_n = ONE_C;
    end else if (host_push_ok) begin
      push_n = host_push_n;
    end

    pop_m = '0;
    if (usb_pop_ok) begin
      pop_m = ONE_C;
    end else if (host_pop_ok) begin
      pop_m = host_pop_m;
    end
  end

  // Per-lane array addresses, write data and read data; lanes wrap modulo DEPTH.
  always_comb begin
    for (int unsigned k = 0; k < HOST_BYTES; k++) begin
      waddr[k]   = AW'(wr_ptr_q + OCC_W'(k));
      raddr[k]   = AW'(rd_ptr_q + OCC_W'(k));
      wbyte[k]   = usb_push_ok ? ((k == 0) ? rx_packet_data : 8'h00)
                               : tx_data[8*k +: 8];
      lane_we[k] = (OCC_W'(k) < push_n);
      rbyte[k]   = mem_q[raddr[k]];
    end
  end

  // Next-state for pointers, occupancy, data outputs and sticky flags.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + push_n;
    rd_ptr_d  = rd_ptr_q + pop_m;
    occ_d     = occ_q + push_n - pop_m;
    tx_byte_d = tx_byte_q;
    rx_word_d = rx_word_q;
    ovf_d     = ovf_q | push_rej;
    udf_d     = udf_q | pop_rej;

    if (usb_pop_ok) begin
      tx_byte_d = rbyte[0];
    end
    if (host_pop_ok) begin
      for (int unsigned k = 0; k < HOST_BYTES; k++) begin
        rx_word_d[8*k +: 8] = (OCC_W'(k) < pop_m) ? rbyte[k] : 8'h00;
      end
    end

    if (kill) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      occ_d     = '0;
      tx_byte_d = '0;
      rx_word_d = '0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      tx_byte_q <= '0;
      rx_word_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      tx_byte_q <= tx_byte_d;
      rx_word_q <= rx_word_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Byte array: write only the accepted lanes; contents survive reset.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < HOST_BYTES; k++) begin
      if (lane_we[k]) begin
        mem_q[waddr[k]] <= wbyte[k];
      end
    end
  end

  assign tx_packet_data   = tx_byte_q;
  assign rx_data          = rx_word_q;
  assign buffer_occupancy = occ_q;
  assign overflow         = ovf_q;
  assign underflow        = udf_q;

`ifdef USB_BUF_WATERMARK_EN
  localparam logic [OCC_W-1:0] HOST_C = OCC_W'(HOST_BYTES);

  logic room_q, room_d;
  logic word_q, word_d;

  // Watermarks follow occupancy_next so they move together with buffer_occupancy.
  always_comb begin
    room_d = ((DEPTH_C - occ_d) >= HOST_C);
    word_d = (occ_d >= HOST_C);
  end

  // Watermark registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      room_q <= 1'b1;
      word_q <= 1'b0;
    end else begin
      room_q <= room_d;
      word_q <= word_d;
    end
  end

  assign room_avail = room_q;
  assign word_avail = word_q;
`endif

endmodule

// File: tb/tb_usb_data_buffer_wide.sv
// tb_usb_data_buffer_wide
// Directed scenarios plus randomized traffic for usb_data_buffer_wide
// (DEPTH=64, HOST_BYTES=4). A byte-queue reference model produces the expected
// post-edge state for every cycle; a monitor compares it against the DUT.
// Watermark ports are checked when USB_BUF_WATERMARK_EN is defined.
module tb_usb_data_buffer_wide;

  localparam int DEPTH = 64;
  localparam int HB    = 4;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst, flush, clear;
  logic              store_rx_packet_data;
  logic [7:0]        rx_packet_data;
  logic              get_tx_packet_data;
  logic [7:0]        tx_packet_data;
  logic              store_tx_data;
  logic [1:0]        tx_size;
  logic [8*HB-1:0]   tx_data;
  logic              get_rx_data;
  logic [1:0]        rx_size;
  logic [8*HB-1:0]   rx_data;
  logic [OCC_W-1:0]  buffer_occupancy;
  logic              overflow, underflow;
`ifdef USB_BUF_WATERMARK_EN
  logic              room_avail, word_avail;
`endif

  always #5 clk = ~clk;

  usb_data_buffer_wide #(
    .DEPTH      (DEPTH),
    .HOST_BYTES (HB)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .clear                (clear),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .store_tx_data        (store_tx_data),
    .tx_size              (tx_size),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_size              (rx_size),
    .rx_data              (rx_data),
    .buffer_occupancy     (buffer_occupancy),
    .overflow             (overflow),
    .underflow            (underflow)
`ifdef USB_BUF_WATERMARK_EN
    ,
    .room_avail           (room_avail),
    .word_avail           (word_avail)
`endif
  );

  typedef struct {
    logic        rst, flush, clear;
    logic        srx;
    logic [7:0]  rxd;
    logic        gtx;
    logic        stx;
    logic [1:0]  tsz;
    logic [31:0] tdat;
    logic        grx;
    logic [1:0]  rsz;
  } stim_t;

  typedef struct {
    logic [7:0]  txo;
    logic [31:0] rxo;
    int          occ;
    logic        ovf, udf;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mq[$];
  logic [7:0]  m_txo;
  logic [31:0] m_rxo;
  logic        m_ovf, m_udf;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // Drive one cycle, advance the reference model, queue the expected result.
  task automatic step(input stim_t s);
    exp_t e;
    int   pre;
    int   n;
    rst = s.rst; flush = s.flush; clear = s.clear;
    store_rx_packet_data = s.srx; rx_packet_data = s.rxd;
    get_tx_packet_data = s.gtx;
    store_tx_data = s.stx; tx_size = s.tsz; tx_data = s.tdat;
    get_rx_data = s.grx; rx_size = s.rsz;

    if (s.rst || s.flush || s.clear) begin
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_txo = '0; m_rxo = '0;
    end else begin
      pre = mq.size();
      // pops first: they only consume bytes that existed before the edge
      if (s.gtx) begin
        if (pre >= 1) m_txo = mq.pop_front();
        else m_udf = 1'b1;
        if (s.grx) m_udf = 1'b1;
      end else if (s.grx) begin
        n = 1 << s.rsz;
        if (s.rsz == 2'd3 || pre < n) m_udf = 1'b1;
        else begin
          m_rxo = '0;
          for (int i = 0; i < n; i++) m_rxo[8*i +: 8] = mq.pop_front();
        end
      end
      // pushes judged on the pre-edge fill level
      if (s.srx) begin
        if (DEPTH - pre >= 1) mq.push_back(s.rxd);
        else m_ovf = 1'b1;
        if (s.stx) m_ovf = 1'b1;
      end else if (s.stx) begin
        n = 1 << s.tsz;
        if (s.tsz == 2'd3 || DEPTH - pre < n) m_ovf = 1'b1;
        else for (int i = 0; i < n; i++) mq.push_back(s.tdat[8*i +: 8]);
      end
    end

    e.txo = m_txo; e.rxo = m_rxo; e.occ = mq.size(); e.ovf = m_ovf; e.udf = m_udf;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic usb_push(input logic [7:0] b);
    stim_t s; s = idle(); s.srx = 1'b1; s.rxd = b; step(s);
  endtask
  task automatic usb_pop();
    stim_t s; s = idle(); s.gtx = 1'b1; step(s);
  endtask
  task automatic host_push(input logic [1:0] sz, input logic [31:0] d);
    stim_t s; s = idle(); s.stx = 1'b1; s.tsz = sz; s.tdat = d; step(s);
  endtask
  task automatic host_pop(input logic [1:0] sz);
    stim_t s; s = idle(); s.grx = 1'b1; s.rsz = sz; step(s);
  endtask
  task automatic do_flush();
    stim_t s; s = idle(); s.flush = 1'b1; step(s);
  endtask
  task automatic nop();
    step(idle());
  endtask

  // Monitor: after every active edge compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_packet_data", 32'(tx_packet_data), 32'(e.txo));
        chk("rx_data", rx_data, e.rxo);
        chk("buffer_occupancy", 32'(buffer_occupancy), 32'(e.occ));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("underflow", 32'(underflow), 32'(e.udf));
`ifdef USB_BUF_WATERMARK_EN
        chk("room_avail", 32'(room_avail), 32'((DEPTH - e.occ) >= HB));
        chk("word_avail", 32'(word_avail), 32'(e.occ >= HB));
`endif
      end
    end
  end

  initial begin
    stim_t s;
    m_txo = '0; m_rxo = '0; m_ovf = 1'b0; m_udf = 1'b0;

    // reset, then reset again mid-transfer with strobes active
    s = idle(); s.rst = 1'b1; step(s); step(s);
    for (int i = 0; i < 5; i++) usb_push(8'(8'h30 + i));
    usb_pop();
    s = idle(); s.rst = 1'b1; s.srx = 1'b1; s.rxd = 8'h55; s.gtx = 1'b1; s.grx = 1'b1;
    step(s); step(s);
    nop();

    // host-to-USB: one 4-byte host push drained byte by byte
    host_push(2'd2, 32'h44332211);
    for (int i = 0; i < 4; i++) usb_pop();
    nop();

    // full boundary: 62 bytes, 4-byte push rejected, 2-byte push fills exactly
    do_flush();
    for (int i = 0; i < 62; i++) usb_push(8'($urandom));
    host_push(2'd2, $urandom);
    host_push(2'd1, $urandom);
    usb_push(8'hEE);
    host_push(2'd0, $urandom);
    for (int i = 0; i < 16; i++) host_pop(2'd2);

    // underflow and widths, illegal size code
    do_flush();
    usb_push(8'hA0); usb_push(8'hA1); usb_push(8'hA2);
    host_pop(2'd2);
    host_pop(2'd1);
    host_pop(2'd3);
    usb_pop();
    usb_pop();
    host_push(2'd3, 32'hDEADBEEF);

    // wrap and concurrency: USB push every cycle, host 4-byte pop every 4th
    do_flush();
    for (int i = 0; i < 200; i++) begin
      s = idle(); s.srx = 1'b1; s.rxd = 8'(i * 7 + 3);
      if (i % 4 == 0 && i > 0) begin s.grx = 1'b1; s.rsz = 2'd2; end
      step(s);
    end
    host_pop(2'd2);
    nop();

    // collisions: both pushes and both pops in one cycle
    s = idle(); s.srx = 1'b1; s.rxd = 8'h5A; s.stx = 1'b1; s.tsz = 2'd1; s.tdat = 32'h0000BEEF;
    step(s);
    s = idle(); s.gtx = 1'b1; s.grx = 1'b1; s.rsz = 2'd0;
    step(s);

    // flush priority at occupancy 10 with overflow set
    do_flush();
    for (int i = 0; i < 9; i++) usb_push(8'(i));
    s = idle(); s.srx = 1'b1; s.rxd = 8'h09; s.stx = 1'b1; s.tsz = 2'd0; s.tdat = 32'h77;
    step(s);
    s = idle(); s.flush = 1'b1; s.stx = 1'b1; s.tsz = 2'd2; s.tdat = 32'hCAFEF00D;
    step(s);
    nop();

    // clear with pops and pushes pending
    host_push(2'd2, 32'h04030201);
    host_pop(2'd1);
    s = idle(); s.clear = 1'b1; s.srx = 1'b1; s.rxd = 8'h99; s.grx = 1'b1; s.rsz = 2'd0;
    step(s);
    nop();

    // randomized mixed traffic
    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.srx   = ($urandom_range(0, 99) < 40);
      s.rxd   = 8'($urandom);
      s.stx   = ($urandom_range(0, 99) < 30);
      s.tsz   = 2'($urandom_range(0, 3));
      s.tdat  = $urandom;
      s.gtx   = ($urandom_range(0, 99) < 30);
      s.grx   = ($urandom_range(0, 99) < 30);
      s.rsz   = 2'($urandom_range(0, 3));
      s.flush = ($urandom_range(0, 99) < 2);
      s.clear = ($urandom_range(0, 99) < 2);
      s.rst   = ($urandom_range(0, 199) < 1);
      step(s);
    end
    nop();
    nop();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
